// File: rtl/frame_decryptor.sv
// rtl/frame_decryptor.sv - serial frame receiver with XOR byte decryption (option: FRAME_DECRYPTOR_KEY_ROT_EN)
module frame_decryptor #(
   parameter logic [7:0] KEY      = 8'hA5,
   parameter int         MAX_BITS = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame,
   input  logic       msg,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       done,
   output logic [5:0] msg_len,
   output logic       error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] MAX_CNT = 6'(MAX_BITS);

   state_t      state;
   state_t      state_nxt;
   logic        frame_d;
   logic [5:0]  bit_cnt;
   logic [7:0]  shift_reg;
   logic        byte_rdy;
   logic [7:0]  key_reg;

   logic        start;
   logic        accept;
   logic        overflow;
   logic        finish;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath strobes; a frame only starts on a rising edge of frame seen in IDLE.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      accept    = 1'b0;
      overflow  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (frame && !frame_d) begin
               start     = 1'b1;
               state_nxt = RECV;
            end
         end
         RECV: begin
            if (frame) begin
               if (bit_cnt < MAX_CNT) begin
                  accept = 1'b1;
               end else begin
                  overflow = 1'b1;
               end
            end else begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Edge detector; resets high so a frame already active at reset release is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_d <= 1'b1;
      end else begin
         frame_d <= frame;
      end
   end

   // Bit capture: shift register, bit counter and the byte-complete marker.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= 8'h00;
         bit_cnt   <= 6'd0;
         byte_rdy  <= 1'b0;
      end else begin
         byte_rdy <= 1'b0;
         if (start) begin
            shift_reg <= {7'b0, msg};
            bit_cnt   <= 6'd1;
         end else if (accept) begin
            shift_reg <= {shift_reg[6:0], msg};
            bit_cnt   <= bit_cnt + 6'd1;
            byte_rdy  <= (bit_cnt[2:0] == 3'd7);
         end
      end
   end

   // Output byte: decrypted one cycle after its eighth bit is captured; held between pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out   <= 8'h00;
         data_valid <= 1'b0;
      end else begin
         data_valid <= byte_rdy;
         if (byte_rdy) begin
            data_out <= shift_reg ^ key_reg;
         end
      end
   end

   // Frame status: done pulse leaving DONE, length latched at frame end, sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         done    <= 1'b0;
         msg_len <= 6'd0;
         error   <= 1'b0;
      end else begin
         done <= (state == DONE);
         if (start) begin
            msg_len <= 6'd0;
            error   <= 1'b0;
         end
         if (overflow) begin
            error <= 1'b1;
         end
         if (finish) begin
            msg_len <= bit_cnt;
            if (bit_cnt[2:0] != 3'd0) begin
               error <= 1'b1;
            end
         end
      end
   end

`ifdef FRAME_DECRYPTOR_KEY_ROT_EN
   // Key rotates left after each decrypted byte and restarts from KEY on every frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_reg <= KEY;
      end else if (start) begin
         key_reg <= KEY;
      end else if (byte_rdy) begin
         key_reg <= {key_reg[6:0], key_reg[7]};
      end
   end
`else
   assign key_reg = KEY;
`endif

endmodule

// File: doc/frame_decryptor.md
FRAME_DECRYPTOR -- requirements
Module: frame_decryptor

Interface
REQ-001 Parameter KEY, default 8'hA5, base XOR decryption key.
REQ-002 Parameter MAX_BITS, default 32, maximum accepted bits per frame; SHALL be a multiple of 8 and at most 63.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame  input  1  frame-active strobe from upstream serializer.
REQ-006 msg  input  1  serial message bit, MSB first, valid while frame=1.
REQ-007 data_out  output  8  decrypted byte.
REQ-008 data_valid  output  1  one-cycle pulse; data_out valid.
REQ-009 done  output  1  one-cycle pulse at end of frame.
REQ-010 msg_len  output  6  bits accepted in last frame; valid from the done pulse until the next frame start.
REQ-011 error  output  1  sticky flag for partial byte or overflow in last frame.

Function
REQ-012 States: IDLE, RECV, DONE; frame_d is a registered copy of frame.
REQ-013 IDLE->RECV on frame=1 and frame_d=0; msg on that same edge is captured as bit 1 of the frame.
REQ-014 On frame start: bit counter=1, msg_len=0, error=0.
REQ-015 RECV with frame=1: msg is shifted into the 8-bit shift register LSB side and the bit counter increments.
REQ-016 When the 8th bit of a byte is captured, data_out=shift_value^key and data_valid=1 on the following edge; latency is exactly 1 cycle.
REQ-017 The bit counter saturates at MAX_BITS; any further frame=1 bit sets error=1 and is discarded, producing no data_valid.
REQ-018 RECV with frame=0: go to DONE; msg_len=bit counter.
REQ-019 If the bit counter mod 8 is not 0 at frame end: error=1 and the partial byte is discarded.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 A frame start while in DONE is ignored; a new frame requires a fresh 0->1 transition seen in IDLE.
REQ-022 data_out holds its last value between pulses; data_valid and done are never high in the same cycle.
REQ-023 A frame of 0 bytes plus partial bits still produces done.

Reset
REQ-024 reset=1 at a clock edge: state=IDLE, data_out=8'h00, data_valid=0, done=0, msg_len=0, error=0, counter=0, shift register=0, key register=KEY.
REQ-025 frame_d SHALL reset to 1, so a frame already high when reset is released is ignored until frame falls and rises again.
REQ-026 Reset mid-frame discards all partial data, with no done or data_valid pulse.

Configuration
REQ-027 Macro FRAME_DECRYPTOR_KEY_ROT_EN.
- Defined: the key register rotates left by 1 after every data_valid and reloads KEY at each frame start.
- Undefined: the key is constant KEY and no rotation logic is present.

Verification
REQ-028 Frame of 8 bits 0x5A, KEY=A5 -> data_out=0xFF with a 1-cycle data_valid, then done, msg_len=8, error=0.
REQ-029 16 bits 0x12,0x34, macro undefined -> data_out 0xB7 then 0x91; with macro defined -> 0xB7 then 0x7F (0x34^0x4B).
REQ-030 5-bit frame -> no data_valid, done=1, msg_len=5, error=1.
REQ-031 40-bit frame -> four data_valid pulses, msg_len=32, error=1, done after frame falls.
REQ-032 Reset released with frame already high for 10 bits -> no capture; next 0->1 frame is decoded normally.
REQ-033 Reset asserted after 12 bits of a 16-bit frame -> one byte output before reset, no done, all outputs 0 after reset.
